// File: rtl/if_id_buf.sv
// Fetch-to-decode decoupling buffer: a small circular FIFO of {pc, inst, exp, int}
// entries. The registered count alone drives if_ready, so there is no fetch<->ID combinational path.
module if_id_buf #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [XLEN-1:0]  if_pc,
  input  logic [XLEN-1:0]  if_inst,
  input  logic             if_exp_flag,
  input  logic             if_int_flag,
  input  logic             id_ready,
  output logic             id_valid,
  output logic [XLEN-1:0]  id_pc,
  output logic [XLEN-1:0]  id_inst,
  output logic             if2id_exp_flag,
  output logic             if2id_int_flag,
  output logic [PTR_W:0]   occupancy
);

  localparam logic [PTR_W:0]  FULL = (PTR_W+1)'(DEPTH);
  localparam logic [XLEN-1:0] NOP  = XLEN'(32'h0000_0013);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            exp_flag;
    logic            int_flag;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push, pop;
  entry_t           wr_entry, head;

  assign if_ready  = (count_q != FULL);
  assign id_valid  = (count_q != '0) && !flush;
  assign push      = if_valid && if_ready && !flush;
  assign pop       = id_valid && id_ready;
  assign occupancy = count_q;

  assign wr_entry = '{pc: if_pc, inst: if_inst, exp_flag: if_exp_flag, int_flag: if_int_flag};

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // pointer width equals log2(DEPTH), so the increment wraps naturally
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data-only; validity lives in count_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  // A bubble (NOP, pc 0, no flags) is presented whenever there is no valid head.
  always_comb begin
    head = mem_q[rd_ptr_q];
    if (id_valid) begin
      id_pc          = head.pc;
      id_inst        = head.inst;
      if2id_exp_flag = head.exp_flag;
      if2id_int_flag = head.int_flag;
    end else begin
      id_pc          = '0;
      id_inst        = NOP;
      if2id_exp_flag = 1'b0;
      if2id_int_flag = 1'b0;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && count_q == FULL));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && count_q == '0));

endmodule

// File: tb/tb_if_id_buf.sv
// Scoreboard bench for if_id_buf: directed scenarios followed by randomized traffic,
// checked against a queue model of the FIFO.
module tb_if_id_buf;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int PTR_W = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             if_valid = 1'b0;
  logic             if_ready;
  logic [XLEN-1:0]  if_pc = '0;
  logic [XLEN-1:0]  if_inst = '0;
  logic             if_exp_flag = 1'b0;
  logic             if_int_flag = 1'b0;
  logic             id_ready = 1'b0;
  logic             id_valid;
  logic [XLEN-1:0]  id_pc;
  logic [XLEN-1:0]  id_inst;
  logic             if2id_exp_flag;
  logic             if2id_int_flag;
  logic [PTR_W:0]   occupancy;

  if_id_buf #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
    .if_exp_flag(if_exp_flag), .if_int_flag(if_int_flag),
    .id_ready(id_ready), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .if2id_exp_flag(if2id_exp_flag), .if2id_int_flag(if2id_int_flag),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            e;
    logic            i;
  } ent_t;

  ent_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: drive after negedge, check control outputs against the model,
  // then update the model for the coming posedge.
  task automatic cycle(input logic v, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] inst,
                       input logic e, input logic i, input logic rdy, input logic fl);
    bit exp_valid, exp_ready;
    @(negedge clk);
    if_valid = v; if_pc = pc; if_inst = inst; if_exp_flag = e; if_int_flag = i;
    id_ready = rdy; flush = fl;
    #2;
    exp_ready = (sb.size() != DEPTH);
    exp_valid = (sb.size() != 0) && !fl;
    chk("occupancy", 64'(occupancy), 64'(sb.size()));
    chk("if_ready", 64'(if_ready), 64'(exp_ready));
    chk("id_valid", 64'(id_valid), 64'(exp_valid));
    if (!exp_valid) begin
      chk("bubble_pc", 64'(id_pc), 64'h0);
      chk("bubble_inst", 64'(id_inst), 64'h13);
      chk("bubble_flags", 64'({if2id_exp_flag, if2id_int_flag}), 64'h0);
    end
    if (fl) sb.delete();
    else if (v && exp_ready) sb.push_back('{pc: pc, inst: inst, e: e, i: i});
  endtask

  // Monitor: compares the presented head against the oldest model entry, retiring it on handshake.
  initial begin
    ent_t f;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && id_valid) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL head_unexpected: got valid pc %0h expected no entry", id_pc);
        end else begin
          f = sb[0];
          chk("head_pc", 64'(id_pc), 64'(f.pc));
          chk("head_inst", 64'(id_inst), 64'(f.inst));
          chk("head_exp", 64'(if2id_exp_flag), 64'(f.e));
          chk("head_int", 64'(if2id_int_flag), 64'(f.i));
          if (id_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) cycle(1'b0, '0, '0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    logic [XLEN-1:0] pc;
    int pv, pr, pf;
    #12 rst_n = 1'b1;

    // fill with ID stalled, third push refused, then stall-release
    cycle(1, 32'h8000_0000, 32'h0000_0113, 0, 0, 0, 0);
    cycle(1, 32'h8000_0004, 32'h0000_0213, 0, 0, 0, 0);
    cycle(1, 32'h8000_0008, 32'h0000_0313, 0, 0, 0, 0);
    idle(3, 1'b0);
    chk("fill_count", 64'(occupancy), 64'd2);
    cycle(1, 32'h8000_000c, 32'h0000_0413, 0, 0, 1, 0);
    idle(3, 1'b1);

    // streaming: 8 back-to-back with ID always ready
    pc = 32'h8000_0100;
    for (int k = 0; k < 8; k++) begin
      cycle(1, pc, $urandom, 0, 0, 1, 0);
      pc += 4;
    end
    idle(2, 1'b1);

    // flush with two queued and if_valid high; next push is first delivered
    cycle(1, 32'h8000_0200, 32'h11, 0, 0, 0, 0);
    cycle(1, 32'h8000_0204, 32'h22, 0, 0, 0, 0);
    cycle(1, 32'h8000_0208, 32'h33, 0, 0, 1, 1);
    cycle(1, 32'h8000_1000, 32'h44, 0, 0, 0, 0);
    idle(2, 1'b1);

    // flags travel with their own entries
    cycle(1, 32'h8000_2000, 32'h55, 1, 0, 0, 0);
    cycle(1, 32'h8000_2004, 32'h66, 0, 1, 0, 0);
    idle(1, 1'b0);
    idle(3, 1'b1);

    // async reset mid-traffic with two entries held
    cycle(1, 32'h8000_3000, 32'h77, 0, 0, 0, 0);
    cycle(1, 32'h8000_3004, 32'h88, 0, 0, 0, 0);
    @(negedge clk);
    if_valid = 1'b0; id_ready = 1'b0; flush = 1'b0;
    #4 rst_n = 1'b0;
    #1;
    chk("rst_id_valid", 64'(id_valid), 64'h0);
    chk("rst_if_ready", 64'(if_ready), 64'h1);
    chk("rst_inst", 64'(id_inst), 64'h13);
    chk("rst_occ", 64'(occupancy), 64'h0);
    sb.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
    idle(2, 1'b1);

    // randomized traffic in phases of varying back-pressure and flush density
    pc = 32'h9000_0000;
    for (int ph = 0; ph < 4; ph++) begin
      pv = 40 + ph * 20; pr = 90 - ph * 25; pf = (ph == 2) ? 15 : 3;
      for (int k = 0; k < 400; k++) begin
        cycle($urandom_range(99) < pv, pc, $urandom, $urandom_range(9) == 0,
              $urandom_range(9) == 0, $urandom_range(99) < pr, $urandom_range(99) < pf);
        pc += 4;
      end
    end
    idle(4, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
